// File: rtl/framebuffer_writer_if.sv
// rtl/framebuffer_writer_if.sv - command and memory-write bus of the framebuffer writer
// Purpose: bundles the draw-command handshake, the display arbitration input,
//          the framebuffer write port and the status outputs.
// Signals (directions seen from the writer, modport slave):
//   cmd_valid   in   command present
//   cmd_ready   out  writer can accept a command
//   cmd_x/y/len in   start column, row, pixel count
//   cmd_red/green/blue in  colour fields
//   on_air      in   display owns memory this cycle
//   mem_address/mem_data/mem_we out  framebuffer write port
//   busy        out  span in progress
//   err         out  one-cycle pulse on a rejected command
interface framebuffer_writer_if #(
  parameter int WIDTH       = 16,
  parameter int COORDINATES = 10,
  parameter int ADDRESS     = 19,
  parameter int RED         = 6,
  parameter int GREEN       = 5,
  parameter int BLUE        = 5
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [COORDINATES-1:0] cmd_x;
  logic [COORDINATES-1:0] cmd_y;
  logic [COORDINATES-1:0] cmd_len;
  logic [RED-1:0]         cmd_red;
  logic [GREEN-1:0]       cmd_green;
  logic [BLUE-1:0]        cmd_blue;
  logic                   on_air;
  logic [ADDRESS-1:0]     mem_address;
  logic [WIDTH-1:0]       mem_data;
  logic                   mem_we;
  logic                   busy;
  logic                   err;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_len, cmd_red, cmd_green, cmd_blue, on_air,
    output cmd_ready, mem_address, mem_data, mem_we, busy, err
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_len, cmd_red, cmd_green, cmd_blue, on_air,
    input  cmd_ready, mem_address, mem_data, mem_we, busy, err
  );
endinterface

// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - turns point/span draw commands into framebuffer writes
// Purpose: accepts a draw command (x, y, len, colour), validates it, clips the
//          span at the line end and emits one write per cycle whenever the
//          display is not reading memory.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    framebuffer_writer_if.slave (command, on_air, write port, status)
module framebuffer_writer #(
  parameter int WIDTH       = 16,
  parameter int COORDINATES = 10,
  parameter int ADDRESS     = 19,
  parameter int RED         = 6,
  parameter int GREEN       = 5,
  parameter int BLUE        = 5,
  parameter int SCREEN_W    = 800,
  parameter int SCREEN_H    = 600
) (
  input logic                clk,
  input logic                rst_n,
  framebuffer_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

  localparam int CW = COORDINATES + 1;
  // One extra bit so the screen limits and the room-to-line-end fit without wrap.
  localparam logic [CW-1:0]          W_LIM    = CW'(SCREEN_W);
  localparam logic [CW-1:0]          H_LIM    = CW'(SCREEN_H);
  localparam logic [COORDINATES-1:0] CNT_ONE  = COORDINATES'(1);
  localparam logic [ADDRESS-1:0]     ADDR_ONE = ADDRESS'(1);

  state_t state, state_next;

  logic [COORDINATES-1:0] x_q, y_q, len_q, remaining;
  logic [RED-1:0]         red_q;
  logic [GREEN-1:0]       green_q;
  logic [BLUE-1:0]        blue_q;

  logic               accept, cmd_bad, we, ready_next, err_next;
  logic [ADDRESS-1:0] base;
  logic [CW-1:0]      room;

  // cmd_ready is only ever high in IDLE, so accept implies IDLE.
  assign accept  = bus.cmd_valid && bus.cmd_ready;
  assign cmd_bad = ({1'b0, bus.cmd_x} >= W_LIM) || ({1'b0, bus.cmd_y} >= H_LIM) ||
                   (bus.cmd_len == '0);

  // Combinational so a write can never land in an on_air cycle.
  assign we         = (state == WRITE) && !bus.on_air;
  assign bus.mem_we = we;

  assign base = ADDRESS'(y_q) * ADDRESS'(SCREEN_W) + ADDRESS'(x_q);
  assign room = W_LIM - {1'b0, x_q};

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_bad) err_next   = 1'b1;
          else         state_next = CALC;
        end
      end
      CALC:    state_next = WRITE;
      WRITE:   if (we && remaining == CNT_ONE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Drop on the accept edge; otherwise ready whenever we will sit in IDLE.
    ready_next = (state_next == IDLE) && !accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state         <= state_next;
      bus.busy      <= (state_next != IDLE);
      bus.cmd_ready <= ready_next;
      bus.err       <= err_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q             <= '0;
      y_q             <= '0;
      len_q           <= '0;
      red_q           <= '0;
      green_q         <= '0;
      blue_q          <= '0;
      remaining       <= '0;
      bus.mem_address <= '0;
      bus.mem_data    <= '0;
    end else begin
      if (accept) begin
        x_q     <= bus.cmd_x;
        y_q     <= bus.cmd_y;
        len_q   <= bus.cmd_len;
        red_q   <= bus.cmd_red;
        green_q <= bus.cmd_green;
        blue_q  <= bus.cmd_blue;
      end
      if (state == CALC) begin
        bus.mem_address <= base;
        bus.mem_data    <= {red_q, green_q, blue_q};
        // Clip at the end of the line; spans never wrap onto the next row.
        remaining       <= ({1'b0, len_q} < room) ? len_q : room[COORDINATES-1:0];
      end else if (we) begin
        bus.mem_address <= bus.mem_address + ADDR_ONE;
        remaining       <= remaining - CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_framebuffer_writer.sv
// tb/tb_framebuffer_writer.sv - self-checking bench for framebuffer_writer
module tb_framebuffer_writer;
  localparam int SW = 800;
  localparam int SH = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  framebuffer_writer_if bus();
  framebuffer_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log: address, data and the clock edge on which each write commits.
  int          wr_addr[$];
  logic [15:0] wr_data[$];
  int          wr_edge[$];
  int          err_cycles = 0;
  int          busy_seen = 0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(int'(bus.mem_address));
      wr_data.push_back(bus.mem_data);
      wr_edge.push_back(cyc + 1);
    end
    if (bus.err === 1'b1) err_cycles++;
    if (bus.busy === 1'b1) busy_seen = 1;
  end

  bit air_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    if (air_rand) bus.on_air = ($urandom_range(0, 3) == 0);
  end

  typedef struct {
    int          x, y, len;
    logic [5:0]  r;
    logic [4:0]  g, b;
    int          exp_err, exp_n, exp_base;
    logic [15:0] exp_data;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    total_cnt++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_edge.delete();
    err_cycles = 0;
    busy_seen  = 0;
  endtask

  task automatic issue_cmd(input int x, input int y, input int len, input logic [5:0] r,
                           input logic [4:0] g, input logic [4:0] b, output int acc_edge);
    int n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout_fail("cmd_ready before issue");
    bus.cmd_x     = 10'(x);
    bus.cmd_y     = 10'(y);
    bus.cmd_len   = 10'(len);
    bus.cmd_red   = r;
    bus.cmd_green = g;
    bus.cmd_blue  = b;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    acc_edge = cyc;
  endtask

  task automatic wait_ready(output int rdy_edge);
    rdy_edge = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin
        rdy_edge = cyc;
        break;
      end
    end
    if (rdy_edge < 0) timeout_fail("cmd_ready after command");
    #1;
  endtask

  task automatic compare_span(input string tag, input int exp_err, input int exp_n,
                              input int exp_base, input logic [15:0] exp_data,
                              input int acc_edge, input int rdy_edge, input bit timing);
    int mism = 0;
    check({tag, " err cycles"}, err_cycles, exp_err);
    check({tag, " write count"}, wr_addr.size(), exp_n);
    for (int i = 0; i < wr_addr.size() && i < exp_n; i++)
      if (wr_addr[i] != exp_base + i || wr_data[i] !== exp_data) mism++;
    check({tag, " addr/data mismatches"}, mism, 0);
    check({tag, " busy seen"}, busy_seen, (exp_err != 0) ? 0 : 1);
    if (timing) begin
      check({tag, " ready latency"}, rdy_edge - acc_edge, (exp_err != 0) ? 1 : exp_n + 1);
      if (exp_err == 0 && wr_edge.size() > 0)
        check({tag, " first write latency"}, wr_edge[0] - acc_edge, 2);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int acc, rdy, n, base, mism;
    logic [15:0] d;

    vecs[0] = '{3,   2,   1, 6'h3F, 5'h00, 5'h00, 0, 1, 1603,   16'hFC00};
    vecs[1] = '{798, 0,   5, 6'h3F, 5'h1F, 5'h1F, 0, 2, 798,    16'hFFFF};
    vecs[2] = '{10,  20,  3, 6'h15, 5'h0A, 5'h05, 0, 3, 16010,  16'h5545};
    vecs[3] = '{800, 10,  4, 6'h01, 5'h01, 5'h01, 1, 0, 0,      16'h0000};
    vecs[4] = '{5,   600, 4, 6'h01, 5'h01, 5'h01, 1, 0, 0,      16'h0000};
    vecs[5] = '{5,   10,  0, 6'h01, 5'h01, 5'h01, 1, 0, 0,      16'h0000};
    vecs[6] = '{799, 599, 1, 6'h00, 5'h1F, 5'h00, 0, 1, 479999, 16'h03E0};

    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_len = '0;
    bus.cmd_red = '0; bus.cmd_green = '0; bus.cmd_blue = '0;
    bus.on_air = 1'b0;

    // Reset state
    #12;
    check("reset cmd_ready", bus.cmd_ready, 0);
    check("reset mem_we", bus.mem_we, 0);
    check("reset busy", bus.busy, 0);
    check("reset err", bus.err, 0);
    check("reset mem_address", bus.mem_address, 0);
    check("reset mem_data", bus.mem_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("cmd_ready before first edge", bus.cmd_ready, 0);
    @(negedge clk);
    check("cmd_ready after first edge", bus.cmd_ready, 1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      clear_log();
      issue_cmd(vecs[i].x, vecs[i].y, vecs[i].len, vecs[i].r, vecs[i].g, vecs[i].b, acc);
      wait_ready(rdy);
      compare_span($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_n, vecs[i].exp_base,
                   vecs[i].exp_data, acc, rdy, 1'b1);
    end

    // Stall: on_air blocks the 2nd and 3rd write opportunities
    clear_log();
    issue_cmd(0, 1, 4, 6'h2A, 5'h11, 5'h0C, acc);
    @(posedge clk);
    @(posedge clk);
    #1 bus.on_air = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 bus.on_air = 1'b0;
    wait_ready(rdy);
    compare_span("stall", 0, 4, 800, {6'h2A, 5'h11, 5'h0C}, acc, rdy, 1'b0);
    if (wr_edge.size() == 4) begin
      check("stall write0 edge", wr_edge[0] - acc, 2);
      check("stall write1 edge", wr_edge[1] - acc, 5);
      check("stall write2 edge", wr_edge[2] - acc, 6);
      check("stall write3 edge", wr_edge[3] - acc, 7);
    end

    // Reset in the middle of a long span
    clear_log();
    issue_cmd(0, 5, 100, 6'h3F, 5'h1F, 5'h1F, acc);
    n = 0;
    while (wr_addr.size() < 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout_fail("mid-span write count");
    rst_n = 1'b0;
    #1;
    check("midreset mem_we", bus.mem_we, 0);
    check("midreset cmd_ready", bus.cmd_ready, 0);
    check("midreset busy", bus.busy, 0);
    check("midreset err", bus.err, 0);
    check("midreset mem_address", bus.mem_address, 0);
    check("midreset mem_data", bus.mem_data, 0);
    mism = 0;
    for (int i = 0; i < wr_addr.size(); i++) if (wr_addr[i] != 4000 + i) mism++;
    check("midreset partial span order", mism, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("post-reset cmd_ready before edge", bus.cmd_ready, 0);
    @(negedge clk);
    check("post-reset cmd_ready after edge", bus.cmd_ready, 1);
    clear_log();
    issue_cmd(0, 0, 1, 6'h01, 5'h02, 5'h03, acc);
    wait_ready(rdy);
    compare_span("post-reset point", 0, 1, 0, 16'h0443, acc, rdy, 1'b1);

    // Randomized commands against a reference model, with random on_air
    air_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int x, y, len;
      logic [5:0] r;
      logic [4:0] g, b;
      x   = $urandom_range(0, 830);
      y   = $urandom_range(0, 620);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 24);
      r   = 6'($urandom);
      g   = 5'($urandom);
      b   = 5'($urandom);
      if (x < SW && y < SH && len != 0) n = (len < SW - x) ? len : SW - x;
      else n = 0;
      base = y * SW + x;
      d = {r, g, b};
      clear_log();
      issue_cmd(x, y, len, r, g, b, acc);
      wait_ready(rdy);
      compare_span($sformatf("rand%0d", k), (n == 0) ? 1 : 0, n, base, d, acc, rdy, 1'b0);
    end
    air_rand = 1'b0;
    #2 bus.on_air = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
